// File: rtl/conv_engine_param.sv
// Streaming KSIZE x KSIZE convolution over a MAPSIZE x MAPSIZE map, one result per window to BRAM.
// Optional build macro: CONV_ENGINE_RELU_EN adds apply_relu and clamps the written value at zero.
module conv_engine_param #(
  parameter int MAPSIZE = 32,
  parameter int KSIZE   = 5,
  parameter int STRIDE  = 1,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int MAC_LAT = 2,
  localparam int OUT_DIM = (MAPSIZE - KSIZE) / STRIDE + 1,
  localparam int OUT_CNT = OUT_DIM * OUT_DIM,
  localparam int AW      = (OUT_CNT > 1) ? $clog2(OUT_CNT) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   accumulate,
`ifdef CONV_ENGINE_RELU_EN
  input  logic                                   apply_relu,
`endif
  input  logic                                   data_valid_in,
  input  logic signed [DATA_W-1:0]               pixel_in,
  input  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] weights,
  output logic [AW-1:0]                          mem_rd_addr,
  input  logic signed [ACC_W-1:0]                mem_rd_data,
  output logic [AW-1:0]                          mem_wr_addr,
  output logic signed [ACC_W-1:0]                mem_wr_data,
  output logic                                   mem_wr_en,
  output logic                                   busy,
  output logic                                   all_done,
  output logic [1:0]                             state_dbg
);

  localparam int RC_W   = (MAPSIZE > 1) ? $clog2(MAPSIZE) : 1;
  localparam int SR_LEN = (KSIZE - 1) * MAPSIZE + KSIZE - 1;
  localparam int SR_N   = (SR_LEN > 0) ? SR_LEN : 1;

  if (ACC_W < 2 * DATA_W + $clog2(KSIZE * KSIZE)) begin : g_acc_w_check
    $error("conv_engine_param: ACC_W too narrow for KSIZE*KSIZE products");
  end

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_e;
  state_e state_q, state_d;

  logic [RC_W-1:0]          row_q, col_q;
  logic                     acc_mode_q;
  logic                     relu_q;
  logic signed [DATA_W-1:0] sr_q [SR_N];
  logic signed [DATA_W-1:0] taps [SR_N+1];
  logic [MAC_LAT-1:0]       pv_q;
  logic signed [ACC_W-1:0]  ps_q [MAC_LAT];
  logic                     r1_vld_q, r2_vld_q;
  logic signed [ACC_W-1:0]  r1_sum_q, r2_sum_q;
  logic [AW-1:0]            r2_addr_q, wr_cnt_q;

  logic                       accept, last_pix, win_ok, pipe_busy;
  int                         row_i, col_i;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    mac_sum, final_sum;

  // Handshake: data_valid_in qualifies pixel_in for one cycle; there is no backpressure,
  // so every valid cycle in STREAM consumes exactly one pixel.
  assign accept    = (state_q == S_STREAM) && data_valid_in;
  assign last_pix  = (row_q == RC_W'(MAPSIZE - 1)) && (col_q == RC_W'(MAPSIZE - 1));
  assign pipe_busy = (|pv_q) || r1_vld_q || r2_vld_q;
  assign busy      = (state_q == S_STREAM) || (state_q == S_FLUSH);
  assign all_done  = (state_q == S_DONE);
  assign state_dbg = state_q;

  always_comb begin
    row_i  = int'(row_q);
    col_i  = int'(col_q);
    win_ok = (row_i >= KSIZE - 1) && (col_i >= KSIZE - 1) &&
             ((row_i - KSIZE + 1) % STRIDE == 0) && ((col_i - KSIZE + 1) % STRIDE == 0);
  end

  // taps[k] is the pixel k positions back in raster order; taps[0] is the incoming one.
  always_comb begin
    taps[0] = pixel_in;
    for (int n = 1; n <= SR_N; n++) taps[n] = sr_q[n-1];
    prod    = '0;
    mac_sum = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        prod    = taps[(KSIZE - 1 - i) * MAPSIZE + (KSIZE - 1 - j)] * $signed(weights[i][j]);
        mac_sum = mac_sum + ACC_W'(prod);
      end
    end
  end

  always_comb begin
    final_sum = r2_sum_q;
    if (acc_mode_q) final_sum = r2_sum_q + mem_rd_data;
`ifdef CONV_ENGINE_RELU_EN
    if (relu_q && final_sum[ACC_W-1]) final_sum = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (accept && last_pix) state_d = S_FLUSH;
      S_FLUSH:  if (!pipe_busy) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      acc_mode_q  <= 1'b0;
      relu_q      <= 1'b0;
      for (int n = 0; n < SR_N; n++) sr_q[n] <= '0;
      pv_q        <= '0;
      for (int k = 0; k < MAC_LAT; k++) ps_q[k] <= '0;
      r1_vld_q    <= 1'b0;
      r2_vld_q    <= 1'b0;
      r1_sum_q    <= '0;
      r2_sum_q    <= '0;
      r2_addr_q   <= '0;
      wr_cnt_q    <= '0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_en   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sr_q[0] <= pixel_in;
        for (int n = 1; n < SR_N; n++) sr_q[n] <= sr_q[n-1];
        if (col_q == RC_W'(MAPSIZE - 1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      pv_q[0] <= accept && win_ok;
      ps_q[0] <= mac_sum;
      for (int k = 1; k < MAC_LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        ps_q[k] <= ps_q[k-1];
      end
      // Read is issued two cycles ahead of the write so BRAM data lines up with r2.
      r1_vld_q <= pv_q[MAC_LAT-1];
      r1_sum_q <= ps_q[MAC_LAT-1];
      if (pv_q[MAC_LAT-1]) begin
        mem_rd_addr <= wr_cnt_q;
        wr_cnt_q    <= wr_cnt_q + 1'b1;
      end
      r2_vld_q  <= r1_vld_q;
      r2_sum_q  <= r1_sum_q;
      r2_addr_q <= mem_rd_addr;
      mem_wr_en <= r2_vld_q;
      if (r2_vld_q) begin
        mem_wr_addr <= r2_addr_q;
        mem_wr_data <= final_sum;
      end
      if (state_q == S_IDLE && start) begin
        acc_mode_q <= accumulate;
`ifdef CONV_ENGINE_RELU_EN
        relu_q     <= apply_relu;
`endif
        row_q      <= '0;
        col_q      <= '0;
        wr_cnt_q   <= '0;
      end
    end
  end

endmodule
